wb_commit_checker: RTL
======================

// Module: wb_commit_checker
// PURPOSE
//  Synthesizable self-check for the 5-stage core. Snoops the writeback stage (reg_wr_en_o3, rd_sel_o3,
//  reg_wr_data_in, PC) and compares each retired register write against a preloaded golden table.
//  Reports pass/fail/timeout and captures the first mismatch in place of $monitor trace dumps.
//  Sits beside top in tb_top and in FPGA bring-up builds; it has no effect on the core.
// PARAMETERS
//  XLEN          32     data/PC width
//  RA_W          5      register-index width
//  EXP_DEPTH     64     golden-table entries (power of 2)
//  TIMEOUT       10000  max RUN cycles before TIMEOUT (>=1)
//  STOP_ON_FAIL  1      1: stop at first mismatch; 0: count all mismatches, end after exp_count commits
// PORTS
//  clk           in   1                 core clock
//  rst           in   1                 async active-high reset
//  start         in   1                 pulse: IDLE->RUN
//  clear         in   1                 pulse: any state->IDLE, clears counters/status
//  exp_wr_en     in   1                 golden-table write (accepted only in IDLE)
//  exp_wr_addr   in   log2(EXP_DEPTH)   table index
//  exp_wr_rd     in   RA_W              expected rd
//  exp_wr_data   in   XLEN              expected write data
//  exp_count     in   log2(EXP_DEPTH)+1 number of valid entries, sampled on start
//  wb_valid      in   1                 writeback enable (reg_wr_en_o3)
//  wb_rd         in   RA_W              writeback rd (rd_sel_o3)
//  wb_data       in   XLEN              writeback data (reg_wr_data_in)
//  wb_pc         in   XLEN              PC of retiring instruction
//  busy          out  1                 state==RUN
//  done          out  1                 state in {PASS,FAIL,TIMEOUT}
//  pass / fail / timeout out 1 each     one-hot terminal status
//  commit_cnt    out  log2(EXP_DEPTH)+1 compared commits
//  mism_cnt      out  log2(EXP_DEPTH)+1 mismatches seen
//  cycle_cnt     out  32                cycles spent in RUN
//  mism_idx      out  log2(EXP_DEPTH)   index of first mismatch
//  mism_pc, mism_exp, mism_got  out XLEN  PC, expected and actual data at first mismatch
//  mism_rd_exp, mism_rd_got     out RA_W  expected and actual rd at first mismatch
// BEHAVIOUR
//  - One clock (clk); reset rst is asynchronous, active-high. Reset: state=IDLE; every output and counter 0.
//    Golden table is NOT reset.
//  - FSM: IDLE -start-> RUN; RUN -> PASS | FAIL | TIMEOUT; terminal states hold until clear or rst.
//    start outside IDLE is ignored. clear has priority over start and over every RUN event.
//  - On start: latch exp_count; commit_cnt, mism_cnt and cycle_cnt are set to 0. If exp_count==0, go to PASS
//    on the next edge.
//  - In RUN, a commit is wb_valid && wb_rd!=0; x0 writes are ignored. A commit compares {wb_rd,wb_data} with
//    table[commit_cnt] and increments commit_cnt. Status and counters update on the same edge, so they are
//    visible 1 cycle after the commit.
//  - Mismatch: if mism_cnt==0, capture mism_idx, mism_pc, mism_exp, mism_got, mism_rd_exp and mism_rd_got
//    (first only); then mism_cnt++.
//    STOP_ON_FAIL=1: go to FAIL on that edge. STOP_ON_FAIL=0: continue.
//  - End of table: when commit_cnt reaches exp_count, go to PASS if mism_cnt==0, else FAIL.
//    Commits after a terminal state are ignored.
//  - cycle_cnt increments every RUN cycle and saturates at 2^32-1. When it reaches TIMEOUT-1 with no
//    terminal event, go to TIMEOUT. A terminal commit on the same edge wins over TIMEOUT.
//  - Table writes are ignored outside IDLE. Table reads are combinational, indexed by commit_cnt.
//    commit_cnt never exceeds exp_count, so reads never wrap.
//  - Async rst in mid-RUN: immediate IDLE and counters 0; the table contents are kept, so a re-run needs no
//    reload.
// TESTING
//  1. Load 3 entries {x1=5,x2=7,x3=12}; start; drive matching commits on cycles 2, 4 and 6 ->
//     pass=1 one cycle after the 3rd commit, commit_cnt=3, mism_cnt=0.
//  2. STOP_ON_FAIL=1, same table; 2nd commit x2=8 -> fail=1 next cycle, mism_idx=1, mism_exp=7,
//     mism_got=8, commit_cnt=2.
//  3. STOP_ON_FAIL=0; mismatches at idx 0 and 2 -> FAIL only after the 3rd commit, mism_cnt=2,
//     mism_idx=0 (first capture kept).
//  4. TIMEOUT=20; start with no commits -> timeout=1 after exactly 20 RUN cycles, cycle_cnt=20.
//     Then a final commit on the timeout edge -> pass=1, timeout=0.
//  5. Interleave wb_valid writes to x0 and exp_wr_en pulses during RUN -> commit_cnt unchanged and
//     table unchanged. exp_count=0 start -> pass next cycle.
//  6. Assert rst asynchronously mid-RUN (between edges) -> all outputs 0 immediately. clear in PASS ->
//     IDLE, counters 0. Start again -> identical pass without reload.

Source files
------------

// File: rtl/wb_commit_checker_if.sv
// Purpose: control, golden-table load, writeback snoop and status bundle for wb_commit_checker.
// Latency: none; this is plain wiring.
// Backpressure: none; the checker only observes writeback and never stalls the core.
interface wb_commit_checker_if #(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int EXP_DEPTH = 64
);
    localparam int AW = $clog2(EXP_DEPTH);
    localparam int CW = AW + 1;

    // control and golden-table load
    logic            start;
    logic            clear;
    logic            exp_wr_en;
    logic [AW-1:0]   exp_wr_addr;
    logic [RA_W-1:0] exp_wr_rd;
    logic [XLEN-1:0] exp_wr_data;
    logic [CW-1:0]   exp_count;

    // writeback snoop
    logic            wb_valid;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] wb_pc;

    // status
    logic            busy;
    logic            done;
    logic            pass;
    logic            fail;
    logic            timeout;
    logic [CW-1:0]   commit_cnt;
    logic [CW-1:0]   mism_cnt;
    logic [31:0]     cycle_cnt;
    logic [AW-1:0]   mism_idx;
    logic [XLEN-1:0] mism_pc;
    logic [XLEN-1:0] mism_exp;
    logic [XLEN-1:0] mism_got;
    logic [RA_W-1:0] mism_rd_exp;
    logic [RA_W-1:0] mism_rd_got;

    modport master (
        output start, clear, exp_wr_en, exp_wr_addr, exp_wr_rd, exp_wr_data, exp_count,
        output wb_valid, wb_rd, wb_data, wb_pc,
        input  busy, done, pass, fail, timeout, commit_cnt, mism_cnt, cycle_cnt,
        input  mism_idx, mism_pc, mism_exp, mism_got, mism_rd_exp, mism_rd_got
    );

    modport slave (
        input  start, clear, exp_wr_en, exp_wr_addr, exp_wr_rd, exp_wr_data, exp_count,
        input  wb_valid, wb_rd, wb_data, wb_pc,
        output busy, done, pass, fail, timeout, commit_cnt, mism_cnt, cycle_cnt,
        output mism_idx, mism_pc, mism_exp, mism_got, mism_rd_exp, mism_rd_got
    );
endinterface

// File: rtl/wb_commit_checker.sv
// Purpose: compares each retired register write against a preloaded golden table and reports pass/fail/timeout.
// Latency: status and counters reflect a commit one cycle after it is seen at writeback.
// Backpressure: none; commits are observed every cycle, and those seen outside RUN are ignored.
module wb_commit_checker #(
    parameter int XLEN         = 32,
    parameter int RA_W         = 5,
    parameter int EXP_DEPTH    = 64,
    parameter int TIMEOUT      = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input logic clk,
    input logic rst,
    wb_commit_checker_if.slave bus
);
    localparam int AW = $clog2(EXP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   exp_cnt_q, exp_cnt_d;
    logic [CW-1:0]   commit_cnt_q, commit_cnt_d;
    logic [CW-1:0]   mism_cnt_q, mism_cnt_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic [AW-1:0]   mism_idx_q, mism_idx_d;
    logic [XLEN-1:0] mism_pc_q, mism_pc_d;
    logic [XLEN-1:0] mism_exp_q, mism_exp_d;
    logic [XLEN-1:0] mism_got_q, mism_got_d;
    logic [RA_W-1:0] mism_rd_exp_q, mism_rd_exp_d;
    logic [RA_W-1:0] mism_rd_got_q, mism_rd_got_d;

    // golden table deliberately has no reset so a re-run after rst needs no reload
    logic [RA_W-1:0] tbl_rd_mem   [EXP_DEPTH];
    logic [XLEN-1:0] tbl_data_mem [EXP_DEPTH];

    logic [RA_W-1:0] rd_exp;
    logic [XLEN-1:0] data_exp;
    logic            commit;
    logic            mismatch;
    logic            terminal;

    // commit_cnt stays below exp_count while running, so this read never wraps
    assign rd_exp   = tbl_rd_mem[commit_cnt_q[AW-1:0]];
    assign data_exp = tbl_data_mem[commit_cnt_q[AW-1:0]];
    assign commit   = bus.wb_valid && (bus.wb_rd != '0);
    assign mismatch = commit && ((bus.wb_rd != rd_exp) || (bus.wb_data != data_exp));

    // table loads are only honoured while idle so a running check sees a stable table
    always_ff @(posedge clk) begin
        if (bus.exp_wr_en && (state_q == S_IDLE)) begin
            tbl_rd_mem[bus.exp_wr_addr]   <= bus.exp_wr_rd;
            tbl_data_mem[bus.exp_wr_addr] <= bus.exp_wr_data;
        end
    end

    // next state: clear beats everything; a terminal commit beats the timeout
    always_comb begin
        state_d       = state_q;
        exp_cnt_d     = exp_cnt_q;
        commit_cnt_d  = commit_cnt_q;
        mism_cnt_d    = mism_cnt_q;
        cycle_cnt_d   = cycle_cnt_q;
        mism_idx_d    = mism_idx_q;
        mism_pc_d     = mism_pc_q;
        mism_exp_d    = mism_exp_q;
        mism_got_d    = mism_got_q;
        mism_rd_exp_d = mism_rd_exp_q;
        mism_rd_got_d = mism_rd_got_q;
        terminal      = 1'b0;

        if (bus.clear) begin
            state_d       = S_IDLE;
            exp_cnt_d     = '0;
            commit_cnt_d  = '0;
            mism_cnt_d    = '0;
            cycle_cnt_d   = '0;
            mism_idx_d    = '0;
            mism_pc_d     = '0;
            mism_exp_d    = '0;
            mism_got_d    = '0;
            mism_rd_exp_d = '0;
            mism_rd_got_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        exp_cnt_d    = bus.exp_count;
                        commit_cnt_d = '0;
                        mism_cnt_d   = '0;
                        cycle_cnt_d  = '0;
                        state_d      = (bus.exp_count == '0) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                        cycle_cnt_d = cycle_cnt_q + 32'd1;
                    end
                    if (commit) begin
                        commit_cnt_d = commit_cnt_q + CW'(1);
                        if (mismatch) begin
                            if (mism_cnt_q == '0) begin
                                mism_idx_d    = commit_cnt_q[AW-1:0];
                                mism_pc_d     = bus.wb_pc;
                                mism_exp_d    = data_exp;
                                mism_got_d    = bus.wb_data;
                                mism_rd_exp_d = rd_exp;
                                mism_rd_got_d = bus.wb_rd;
                            end
                            mism_cnt_d = mism_cnt_q + CW'(1);
                            if (STOP_ON_FAIL != 0) begin
                                state_d  = S_FAIL;
                                terminal = 1'b1;
                            end
                        end
                        if (!terminal && (commit_cnt_d == exp_cnt_q)) begin
                            state_d  = (mism_cnt_d == '0) ? S_PASS : S_FAIL;
                            terminal = 1'b1;
                        end
                    end
                    if (!terminal && (cycle_cnt_q == TO_LAST)) begin
                        state_d = S_TIMEOUT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // state and counters; golden table is kept across reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            exp_cnt_q     <= '0;
            commit_cnt_q  <= '0;
            mism_cnt_q    <= '0;
            cycle_cnt_q   <= '0;
            mism_idx_q    <= '0;
            mism_pc_q     <= '0;
            mism_exp_q    <= '0;
            mism_got_q    <= '0;
            mism_rd_exp_q <= '0;
            mism_rd_got_q <= '0;
        end else begin
            state_q       <= state_d;
            exp_cnt_q     <= exp_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
            mism_cnt_q    <= mism_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            mism_idx_q    <= mism_idx_d;
            mism_pc_q     <= mism_pc_d;
            mism_exp_q    <= mism_exp_d;
            mism_got_q    <= mism_got_d;
            mism_rd_exp_q <= mism_rd_exp_d;
            mism_rd_got_q <= mism_rd_got_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    assign bus.pass        = (state_q == S_PASS);
    assign bus.fail        = (state_q == S_FAIL);
    assign bus.timeout     = (state_q == S_TIMEOUT);
    assign bus.commit_cnt  = commit_cnt_q;
    assign bus.mism_cnt    = mism_cnt_q;
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.mism_idx    = mism_idx_q;
    assign bus.mism_pc     = mism_pc_q;
    assign bus.mism_exp    = mism_exp_q;
    assign bus.mism_got    = mism_got_q;
    assign bus.mism_rd_exp = mism_rd_exp_q;
    assign bus.mism_rd_got = mism_rd_got_q;
endmodule
